vdp_cmd_seq: RTL and testbench

Command sequencer in front of the tms9918 host port. It accepts high-level commands (register write, VRAM fill, VRAM single-byte write, VRAM read) over a valid/ready handshake. It expands each command into correctly timed mode/wr/rd byte accesses on the VDP port. It sits between the CPU/loader logic and the tms9918 instance, replacing hand-sequenced two-byte control writes.

---
 rtl/vdp_cmd_seq_pkg.sv | 40 ++++
 rtl/vdp_cmd_seq_if.sv | 33 +++
 rtl/vdp_cmd_seq_strobe.sv | 116 +++++++++++
 rtl/vdp_cmd_seq.sv | 113 +++++++++++
 tb/tb_vdp_cmd_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_cmd_seq_pkg.sv
// Shared encodings for the VDP command sequencer: opcodes, control-byte prefixes,
// FSM state codes and the byte-selection helper used when launching an access.
package vdp_pkg;

  localparam logic [1:0] OP_REG_WR = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;
  localparam logic [1:0] OP_WRITE1 = 2'd3;

  localparam logic [7:0] CTRL_REG = 8'h80;
  localparam logic [7:0] CTRL_WR  = 8'h40;
  localparam logic [7:0] CTRL_RD  = 8'h00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CTRL0 = 3'd1;
  localparam logic [2:0] ST_CTRL1 = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

  // Byte placed on the VDP port for the access that state 'st' performs.
  function automatic logic [7:0] accessByte(input logic [2:0]  st,
                                            input logic [1:0]  op,
                                            input logic [2:0]  regIdx,
                                            input logic [13:0] addr,
                                            input logic [7:0]  data);
    logic [7:0] b;
    b = data;
    case (st)
      ST_CTRL0: b = (op == OP_REG_WR) ? data : addr[7:0];
      ST_CTRL1: begin
        if (op == OP_REG_WR)    b = CTRL_REG | {5'b0, regIdx};
        else if (op == OP_READ) b = CTRL_RD  | {2'b0, addr[13:8]};
        else                    b = CTRL_WR  | {2'b0, addr[13:8]};
      end
      default: b = data;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vdp_cmd_seq_if.sv
// Command/response handshake plus the tms9918 host-port pins of the sequencer.
interface vdp_cmd_seq_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_reg;
  logic [13:0] cmd_addr;
  logic [13:0] cmd_len;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        vdp_mode;
  logic [7:0]  vdp_addr;
  logic [7:0]  vdp_wdata;
  logic        vdp_wr;
  logic        vdp_rd;
  logic [7:0]  vdp_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_addr, cmd_len, cmd_data, vdp_rdata,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  vdp_mode, vdp_addr, vdp_wdata, vdp_wr, vdp_rd
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_addr, cmd_len, cmd_data, vdp_rdata,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output vdp_mode, vdp_addr, vdp_wdata, vdp_wr, vdp_rd
  );

endinterface

// File: rtl/vdp_cmd_seq_strobe.sv
// Single byte-access engine: SETUP, then a write strobe or RD_CYCLES of read strobe,
// then ACCESS_GAP idle cycles. done_o marks the last gap cycle so a new start chains in.
module vdp_bus_strobe #(
  parameter int ACCESS_GAP = 2,
  parameter int RD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       is_read_i,
  input  logic       mode_i,
  input  logic [7:0] byte_i,
  input  logic [7:0] vdp_rdata_i,
  output logic       done_o,
  output logic       rvalid_o,
  output logic [7:0] rdata_o,
  output logic       mode_o,
  output logic [7:0] wdata_o,
  output logic       wr_o,
  output logic       rd_o
);

  localparam int MAXC = (ACCESS_GAP > RD_CYCLES) ? ACCESS_GAP : RD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(ACCESS_GAP - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_SETUP  = 3'd1;
  localparam logic [2:0] PH_STROBE = 3'd2;
  localparam logic [2:0] PH_RD     = 3'd3;
  localparam logic [2:0] PH_GAP    = 3'd4;

  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic [7:0]    byte_q, byte_d;
  logic          isRead_q, isRead_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  assign done_o   = (phase_q == PH_GAP) && (cnt_q == '0);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign mode_o   = mode_q;
  assign wdata_o  = byte_q;
  assign wr_o     = (phase_q == PH_STROBE);
  assign rd_o     = (phase_q == PH_RD);

  // A start on the final gap cycle goes straight to SETUP, so accesses chain with no bubble.
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    byte_d   = byte_q;
    isRead_d = isRead_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (phase_q)
      PH_SETUP: begin
        if (isRead_q) begin
          phase_d = PH_RD;
          cnt_d   = RD_LAST;
        end else begin
          phase_d = PH_STROBE;
        end
      end
      PH_STROBE: begin
        phase_d = PH_GAP;
        cnt_d   = GAP_LAST;
      end
      PH_RD: begin
        if (cnt_q == '0) begin
          phase_d  = PH_GAP;
          cnt_d    = GAP_LAST;
          rdata_d  = vdp_rdata_i;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PH_GAP: begin
        if (cnt_q == '0) phase_d = PH_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: phase_d = PH_IDLE;
    endcase
    if (start_i) begin
      phase_d  = PH_SETUP;
      mode_d   = mode_i;
      byte_d   = byte_i;
      isRead_d = is_read_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      byte_q   <= 8'h00;
      isRead_q <= 1'b0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      byte_q   <= byte_d;
      isRead_q <= isRead_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: rtl/vdp_cmd_seq.sv
// Command sequencer for the tms9918 host port: expands register/fill/read/write commands
// into control and data byte accesses executed by vdp_bus_strobe.
module vdp_cmd_seq
  import vdp_pkg::*;
#(
  parameter int ACCESS_GAP = 2,
  parameter int RD_CYCLES  = 4
) (
  input logic          clk,
  input logic          reset,
  vdp_cmd_seq_if.slave bus
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  regIdx_q, regIdx_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [13:0] remCount_q, remCount_d;
  logic        accept;
  logic        start;
  logic        isRead;
  logic        accMode;
  logic [7:0]  accByte;
  logic        accDone;
  logic        strobeWr;

  // cmd_ready is held low for the whole time reset is asserted, not just after its first edge.
  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.vdp_addr  = 8'h00;
  assign bus.vdp_wr    = strobeWr;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    regIdx_d   = regIdx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    remCount_d = remCount_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_CTRL0;
          op_d       = bus.cmd_op;
          regIdx_d   = bus.cmd_reg;
          addr_d     = bus.cmd_addr;
          data_d     = bus.cmd_data;
          remCount_d = (bus.cmd_op == OP_WRITE1) ? 14'd1 : bus.cmd_len;
        end
      end
      ST_CTRL0: if (accDone) state_d = ST_CTRL1;
      ST_CTRL1: begin
        if (accDone) begin
          if (op_q == OP_REG_WR)     state_d = ST_IDLE;
          else if (op_q == OP_READ)  state_d = ST_READ;
          else if (remCount_q == '0) state_d = ST_IDLE;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (strobeWr) remCount_d = remCount_q - 14'd1;
        if (accDone)  state_d    = (remCount_q == '0) ? ST_IDLE : ST_DATA;
      end
      ST_READ: if (accDone) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    start   = (state_d != ST_IDLE) && (accept || accDone);
    isRead  = (state_d == ST_READ);
    accMode = (state_d == ST_CTRL0) || (state_d == ST_CTRL1);
    accByte = accessByte(state_d, op_d, regIdx_d, addr_d, data_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_REG_WR;
      regIdx_q   <= 3'd0;
      addr_q     <= 14'd0;
      data_q     <= 8'h00;
      remCount_q <= 14'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      regIdx_q   <= regIdx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      remCount_q <= remCount_d;
    end
  end

  vdp_bus_strobe #(
    .ACCESS_GAP(ACCESS_GAP),
    .RD_CYCLES (RD_CYCLES)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .is_read_i  (isRead),
    .mode_i     (accMode),
    .byte_i     (accByte),
    .vdp_rdata_i(bus.vdp_rdata),
    .done_o     (accDone),
    .rvalid_o   (bus.rsp_valid),
    .rdata_o    (bus.rsp_data),
    .mode_o     (bus.vdp_mode),
    .wdata_o    (bus.vdp_wdata),
    .wr_o       (strobeWr),
    .rd_o       (bus.vdp_rd)
  );

endmodule

// File: tb/tb_vdp_cmd_seq.sv
// Directed bench for vdp_cmd_seq: table of single commands with hand-computed strobe logs,
// plus back-to-back and reset-abort sequences.
module tb_vdp_cmd_seq;
  import vdp_pkg::*;

  typedef struct {
    logic [1:0]       op;
    logic [2:0]       rg;
    logic [13:0]      addr;
    logic [13:0]      len;
    logic [7:0]       data;
    logic [7:0]       stub;
    int               nWr;
    logic [0:4][7:0]  wb;
    logic [0:4]       wm;
    logic [0:4][7:0]  wc;
    int               readyCyc;
    int               nRd;
    int               rdFirst;
    int               nRsp;
    int               rspCyc;
    logic [7:0]       rspData;
  } vec_t;

  logic clk;
  logic reset;
  logic [7:0] stubByte;
  vdp_cmd_seq_if bus();

  vdp_cmd_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.vdp_rdata = bus.vdp_rd ? stubByte : 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t0 = 0;
  bit logEn = 0;
  logic [7:0] logB[$];
  logic       logM[$];
  int         logC[$];
  int rdCnt = 0, rdFirst = 0, rdModeBad = 0;
  int rspCnt = 0, rspCyc = 0;
  logic [7:0] rspD = 8'h00;
  int conflicts = 0;
  logic prevMode = 1'b0;
  vec_t vecs[7];

  // Monitor: log every strobe with its cycle relative to the accepted command.
  always @(negedge clk) begin
    if (logEn) begin
      if (bus.vdp_wr === 1'b1) begin
        logB.push_back(bus.vdp_wdata);
        logM.push_back(bus.vdp_mode);
        logC.push_back(cyc - t0);
      end
      if (bus.vdp_rd === 1'b1) begin
        if (rdCnt == 0) rdFirst = cyc - t0;
        rdCnt++;
        if (bus.vdp_mode !== 1'b0) rdModeBad++;
      end
      if (bus.rsp_valid === 1'b1) begin
        rspCnt++;
        rspCyc = cyc - t0;
        rspD = bus.rsp_data;
      end
    end
    if (bus.vdp_wr === 1'b1 && bus.vdp_rd === 1'b1) conflicts++;
    if ((bus.vdp_wr === 1'b1 || bus.vdp_rd === 1'b1) && bus.vdp_mode !== prevMode) conflicts++;
    prevMode = bus.vdp_mode;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    logB.delete();
    logM.delete();
    logC.delete();
    rdCnt = 0;
    rdFirst = 0;
    rdModeBad = 0;
    rspCnt = 0;
    rspCyc = 0;
    rspD = 8'h00;
    conflicts = 0;
  endtask

  task automatic driveCmd(input logic [1:0] op, input logic [2:0] rg, input logic [13:0] addr,
                          input logic [13:0] len, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_reg = rg;
    bus.cmd_addr = addr;
    bus.cmd_len = len;
    bus.cmd_data = data;
  endtask

  // Wait (bounded) for cmd_ready at a negedge; returns the relative cycle it was seen.
  task automatic waitReady(input string name, output int seenCyc);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
    seenCyc = cyc - t0;
  endtask

  task automatic applyStimulus(input vec_t v, input string name, output int readySeen);
    @(negedge clk);
    stubByte = v.stub;
    driveCmd(v.op, v.rg, v.addr, v.len, v.data);
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    clearLogs();
    logEn = 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput({name, " busy@1"}, 32'(bus.busy), 32'd1);
    checkOutput({name, " ready@1"}, 32'(bus.cmd_ready), 32'd0);
    waitReady(name, readySeen);
    logEn = 0;
  endtask

  task automatic checkVector(input vec_t v, input string name, input int readySeen);
    checkOutput({name, " ready cycle"}, 32'(readySeen), 32'(v.readyCyc));
    checkOutput({name, " wr count"}, 32'(logB.size()), 32'(v.nWr));
    for (int k = 0; k < v.nWr; k++) begin
      if (k < logB.size()) begin
        checkOutput($sformatf("%s wr%0d byte", name, k), 32'(logB[k]), 32'(v.wb[k]));
        checkOutput($sformatf("%s wr%0d mode", name, k), 32'(logM[k]), 32'(v.wm[k]));
        checkOutput($sformatf("%s wr%0d cycle", name, k), 32'(logC[k]), 32'(v.wc[k]));
      end
    end
    checkOutput({name, " rd cycles"}, 32'(rdCnt), 32'(v.nRd));
    if (v.nRd > 0) checkOutput({name, " rd first"}, 32'(rdFirst), 32'(v.rdFirst));
    checkOutput({name, " rsp count"}, 32'(rspCnt), 32'(v.nRsp));
    if (v.nRsp > 0) begin
      checkOutput({name, " rsp data"}, 32'(rspD), 32'(v.rspData));
      checkOutput({name, " rsp cycle"}, 32'(rspCyc), 32'(v.rspCyc));
    end
    checkOutput({name, " rd mode"}, 32'(rdModeBad), 32'd0);
    checkOutput({name, " strobe rules"}, 32'(conflicts), 32'd0);
  endtask

  initial begin
    int rs;
    int n;
    vecs[0] = '{op:OP_REG_WR, rg:3'd7, addr:14'h0000, len:14'd0, data:8'hF2, stub:8'h00, nWr:2,
                wb:{8'hF2, 8'h87, 8'h00, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd0, 8'd0, 8'd0},
                readyCyc:9, nRd:0, rdFirst:0, nRsp:0, rspCyc:0, rspData:8'h00};
    vecs[1] = '{op:OP_FILL, rg:3'd0, addr:14'h0800, len:14'd3, data:8'h70, stub:8'h00, nWr:5,
                wb:{8'h00, 8'h48, 8'h70, 8'h70, 8'h70}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd10, 8'd14, 8'd18},
                readyCyc:21, nRd:0, rdFirst:0, nRsp:0, rspCyc:0, rspData:8'h00};
    vecs[2] = '{op:OP_FILL, rg:3'd0, addr:14'h3FFF, len:14'd0, data:8'h11, stub:8'h00, nWr:2,
                wb:{8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd0, 8'd0, 8'd0},
                readyCyc:9, nRd:0, rdFirst:0, nRsp:0, rspCyc:0, rspData:8'h00};
    vecs[3] = '{op:OP_WRITE1, rg:3'd0, addr:14'h1234, len:14'h2000, data:8'hEE, stub:8'h00, nWr:3,
                wb:{8'h34, 8'h52, 8'hEE, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd10, 8'd0, 8'd0},
                readyCyc:13, nRd:0, rdFirst:0, nRsp:0, rspCyc:0, rspData:8'h00};
    vecs[4] = '{op:OP_READ, rg:3'd0, addr:14'h1234, len:14'd0, data:8'h00, stub:8'h5A, nWr:2,
                wb:{8'h34, 8'h12, 8'h00, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd0, 8'd0, 8'd0},
                readyCyc:16, nRd:4, rdFirst:10, nRsp:1, rspCyc:14, rspData:8'h5A};
    vecs[5] = '{op:OP_READ, rg:3'd0, addr:14'h2C01, len:14'd9, data:8'h00, stub:8'hC3, nWr:2,
                wb:{8'h01, 8'h2C, 8'h00, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd0, 8'd0, 8'd0},
                readyCyc:16, nRd:4, rdFirst:10, nRsp:1, rspCyc:14, rspData:8'hC3};
    vecs[6] = '{op:OP_REG_WR, rg:3'd5, addr:14'h3FFF, len:14'd4, data:8'h3C, stub:8'h00, nWr:2,
                wb:{8'h3C, 8'h85, 8'h00, 8'h00, 8'h00}, wm:5'b11000, wc:{8'd2, 8'd6, 8'd0, 8'd0, 8'd0},
                readyCyc:9, nRd:0, rdFirst:0, nRsp:0, rspCyc:0, rspData:8'h00};

    reset = 1'b1;
    stubByte = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_reg = 3'd0;
    bus.cmd_addr = 14'd0;
    bus.cmd_len = 14'd0;
    bus.cmd_data = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset rsp_data", 32'(bus.rsp_data), 32'h00);
    checkOutput("reset vdp_mode", 32'(bus.vdp_mode), 32'd0);
    checkOutput("reset vdp_wr", 32'(bus.vdp_wr), 32'd0);
    checkOutput("reset vdp_rd", 32'(bus.vdp_rd), 32'd0);
    checkOutput("reset vdp_wdata", 32'(bus.vdp_wdata), 32'h00);
    checkOutput("reset vdp_addr", 32'(bus.vdp_addr), 32'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("post-reset busy", 32'(bus.busy), 32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i), rs);
      checkVector(vecs[i], $sformatf("v%0d", i), rs);
    end

    $display("[TB] back-to-back REG_WR then WRITE1");
    @(negedge clk);
    driveCmd(OP_REG_WR, 3'd7, 14'h0000, 14'd0, 8'hF2);
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    clearLogs();
    logEn = 1;
    @(negedge clk);
    waitReady("b2b first", rs);
    checkOutput("b2b first ready cycle", 32'(rs), 32'd9);
    driveCmd(OP_WRITE1, 3'd0, 14'h1234, 14'd7, 8'hEE);
    @(negedge clk);
    checkOutput("b2b second accepted", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    waitReady("b2b second", rs);
    logEn = 0;
    checkOutput("b2b ready cycle", 32'(rs), 32'd22);
    checkOutput("b2b wr count", 32'(logB.size()), 32'd5);
    begin
      logic [7:0] expB[5];
      int expC[5];
      expB = '{8'hF2, 8'h87, 8'h34, 8'h52, 8'hEE};
      expC = '{2, 6, 11, 15, 19};
      for (int k = 0; k < 5; k++) begin
        if (k < logB.size()) begin
          checkOutput($sformatf("b2b wr%0d byte", k), 32'(logB[k]), 32'(expB[k]));
          checkOutput($sformatf("b2b wr%0d cycle", k), 32'(logC[k]), 32'(expC[k]));
        end
      end
    end
    checkOutput("b2b strobe rules", 32'(conflicts), 32'd0);

    $display("[TB] reset during FILL data phase");
    @(negedge clk);
    driveCmd(OP_FILL, 3'd0, 14'h0000, 14'd80, 8'h3C);
    @(posedge clk);
    #1;
    t0 = cyc - 1;
    clearLogs();
    logEn = 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.vdp_wr === 1'b1 && bus.vdp_mode === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort data strobe seen", 32'(n < 300), 32'd1);
    checkOutput("abort first data cycle", 32'(cyc - t0), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort wr low", 32'(bus.vdp_wr), 32'd0);
    checkOutput("abort rd low", 32'(bus.vdp_rd), 32'd0);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort ready in reset", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    clearLogs();
    repeat (40) @(negedge clk);
    logEn = 0;
    checkOutput("abort no strobes", 32'(logB.size() + rdCnt), 32'd0);
    checkOutput("abort no rsp", 32'(rspCnt), 32'd0);
    checkOutput("abort idle ready", 32'(bus.cmd_ready), 32'd1);
    applyStimulus(vecs[0], "after-abort", rs);
    checkVector(vecs[0], "after-abort", rs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
